game_seq: RTL and testbench
===========================

# game_seq

Parametrised game sequencer for the invader core: runs the level progression, counts destroyed invaders against a per-level target, tracks player lives, and accumulates a saturating binary score clocked entirely on `s_clk`. It sits between the pixel-collision logic and the invader, player, and HUD renderers, replacing the fixed five-level controller. It also removes the derived-clock score adder.

## Interface
- `NUM_LEVELS`, default 5: number of levels, range 1–7.
- `INV_W`, default 24: width of the invader-enable mask.
- `SCORE_W`, default 10: width of the binary score.
- `LIVES`, default 3: lives at game start, range 1–7.
- `s_clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `cont_btn`  in  1  continue button, level-sensitive. Only its rising edge is used.
- `ship_pixel`, `shot_pixel`  in  1  collision pixels. A rising edge of their AND counts as one kill.
- `player_hit`  in  1  player struck this cycle. Level-sensitive; only its rising edge is used.
- `line_crossed`  in  1  invaders reached the defence line.
- `lvl_start`  out  1  level active.
- `player_en`  out  1  player enable.
- `level`  out  3  current level, 1-based; 0 in idle.
- `mode`  out  3  HUD mode code.
- `inv_en`  out  INV_W  invader enable mask.
- `lives_left`  out  3  remaining lives.
- `score_bin`  out  SCORE_W  binary score.
- `score_bcd`  out  12  BCD score, hundreds/tens/ones. Present only with the macro (see Configuration).

## Operation
- States:
  - IDLE: mode `M_IDLE`.
  - PLAY: mode `M_PLAY`.
  - PAUSE: mode `M_CLEAR`; entered after a life loss.
  - CLEAR: mode `M_CLEAR`; entered after a level is cleared.
  - WIN: mode `M_WIN`.
  - LOSE: mode `M_LOSE`.
- Reset values: state IDLE, `level`=0, `mode`=`M_IDLE`, `inv_en`=0, `lvl_start`=0, `player_en`=0, `lives_left`=`LIVES`, `score_bin`=0, kill counter 0, all edge-detect registers 0.
- IDLE → PLAY on a `cont_btn` edge:
  - clear `score_bin` and set `lives_left`=`LIVES`;
  - set `level`=1 and `inv_en`=`lvl_mask(1)`;
  - set `lvl_start` and `player_en` to 1.
- PLAY:
  - A kill edge increments the kill counter and adds `level` to the score. The score saturates at 2^SCORE_W−1.
  - When the kill counter equals `popcount(lvl_mask(level))`: go to CLEAR if `level`<`NUM_LEVELS`, otherwise to WIN.
  - On `line_crossed`: go to LOSE.
  - On a `player_hit` edge: decrement `lives_left`. Go to LOSE if it reaches 0, otherwise to PAUSE.
- CLEAR, then `cont_btn` edge → PLAY at `level`+1 with the kill counter cleared.
- PAUSE, then `cont_btn` edge → PLAY at the same level. The kill counter is kept; `inv_en` is unchanged.
- In every state except PLAY: `lvl_start`, `player_en`, and `inv_en` are 0. In PAUSE, `inv_en` holds its value internally so it can be restored on return to PLAY.
- WIN and LOSE hold their state until `rst`. The score stays visible.
- Kill edges outside PLAY are ignored.
- Priority within a single PLAY cycle:
  - `line_crossed` beats a level clear, which beats `player_hit`.
  - A kill that completes the target on the same cycle as `player_hit` clears the level and costs no life.
  - The kill is always scored before any transition.
- Kill counter width is $clog2(INV_W+1). Score arithmetic is at least (SCORE_W+1) bits wide before saturation.

## Timing
- Edge detectors are registered. An input high at edge N is detected at edge N+1; the detection is held low while the input stays high.
- `score_bin` and the kill counter update one cycle after detection.
- The state transition caused by the final kill occurs on the edge after the counter reaches the target.
- All outputs are registered, with no combinational path from input to output.
- `rst` low mid-game returns every output to its reset value on the next edge, including the score.

## Configuration
- `GAME_SEQ_BCD_EN` defined:
  - instantiates `bin2bcd_seq`, a shift-add-3 converter of SCORE_W cycles, restarted whenever `score_bin` changes;
  - `score_bcd` is refreshed when a conversion completes and reads 0 after reset.
- Not defined: `score_bcd` port and converter are absent. The HUD uses `score_bin`.

## Structure
- Package `game_pkg` holds:
  - the mode codes `M_IDLE`=0, `M_PLAY`=1, `M_CLEAR`=2, `M_WIN`=3, `M_LOSE`=4;
  - the state enum;
  - function `lvl_mask(level)`: levels 1–5 return h00aa55, h005aff, haa55ff, h3cffff, hffffff, masked to INV_W. Levels above 5 return all ones.
  - function `popcount`.
- One sub-module: `bin2bcd_seq`, only when the macro is defined.

## Test plan
- Reset, then a `cont_btn` pulse → `level`=1, `inv_en`=h00aa55, `mode`=1, `lives_left`=3.
- Eight kill edges in level 1 → `score_bin`=8, state CLEAR, `mode`=2. Then `cont_btn` → `level`=2, `inv_en`=h005aff.
- `ship_pixel`&`shot_pixel` held high for 10 cycles → exactly one kill and `score_bin` increments by `level` once.
- Three separated `player_hit` pulses, with `cont_btn` between them → `lives_left` goes 2, 1, 0, then `mode`=4. The kill counter is preserved across the PAUSE states.
- Last kill on the same cycle as `line_crossed` → LOSE, with `score_bin` including that kill. Last kill on the same cycle as `player_hit` → CLEAR with `lives_left` unchanged.
- SCORE_W=4 with the full game played → `score_bin` saturates at 15. With `GAME_SEQ_BCD_EN` defined, `score_bcd`=h015 within SCORE_W+2 cycles. `rst` asserted mid-level → all outputs return to their reset values.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: HUD mode codes, sequencer states and level-mask helpers for game_seq.
package game_pkg;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_PLAY  = 3'd1;
    localparam logic [2:0] M_CLEAR = 3'd2;
    localparam logic [2:0] M_WIN   = 3'd3;
    localparam logic [2:0] M_LOSE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE,
        S_CLEAR,
        S_WIN,
        S_LOSE
    } state_t;

    // Callers cast the result down to their own mask width.
    function automatic logic [63:0] lvl_mask(input logic [2:0] lvl);
        return lvl == 3'd0 ? 64'h0      :
               lvl == 3'd1 ? 64'h00aa55 :
               lvl == 3'd2 ? 64'h005aff :
               lvl == 3'd3 ? 64'haa55ff :
               lvl == 3'd4 ? 64'h3cffff :
               lvl == 3'd5 ? 64'hffffff : '1;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) cnt = cnt + 7'(v[i]);
        return cnt;
    endfunction

    function automatic logic [2:0] mode_of(input state_t s);
        return s == S_IDLE                    ? M_IDLE  :
               s == S_PLAY                    ? M_PLAY  :
               (s == S_PAUSE || s == S_CLEAR) ? M_CLEAR :
               s == S_WIN                     ? M_WIN   : M_LOSE;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 converter, W cycles per conversion, restarted on any input change.
module bin2bcd_seq #(
    parameter int W = 10
) (
    input  logic         s_clk,
    input  logic         rst,
    input  logic [W-1:0] bin,
    output logic [11:0]  bcd
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  last_q, last_d, sh_q, sh_d;
    logic [11:0]   acc_q, acc_d, bcd_q, bcd_d, adj, stepped;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 3; i++) adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
        stepped = (adj << 1) | 12'(sh_q[W-1]);
        last_d  = last_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        if (bin != last_q) begin
            last_d = bin;
            sh_d   = bin;
            acc_d  = '0;
            cnt_d  = CW'(W);
        end else if (cnt_q != '0) begin
            acc_d = stepped;
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CW'(1);
            bcd_d = cnt_q == CW'(1) ? stepped : bcd_q;
        end
    end

    always_ff @(posedge s_clk) begin
        if (!rst) begin
            last_q <= '0;
            sh_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            bcd_q  <= '0;
        end else begin
            last_q <= last_d;
            sh_q   <= sh_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            bcd_q  <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/game_seq.sv
// game_seq: level/kill/lives/score sequencer for the invader core on s_clk.
// Define GAME_SEQ_BCD_EN to add the score_bcd port and its bin2bcd_seq converter.
module game_seq
    import game_pkg::*;
#(
    parameter int NUM_LEVELS = 5,
    parameter int INV_W      = 24,
    parameter int SCORE_W    = 10,
    parameter int LIVES      = 3
) (
    input  logic               s_clk,
    input  logic               rst,
    input  logic               cont_btn,
    input  logic               ship_pixel,
    input  logic               shot_pixel,
    input  logic               player_hit,
    input  logic               line_crossed,
    output logic               lvl_start,
    output logic               player_en,
    output logic [2:0]         level,
    output logic [2:0]         mode,
    output logic [INV_W-1:0]   inv_en,
    output logic [2:0]         lives_left,
    output logic [SCORE_W-1:0] score_bin
`ifdef GAME_SEQ_BCD_EN
    ,
    output logic [11:0]        score_bcd
`endif
);
    localparam int KW = $clog2(INV_W + 1);
    localparam int AW = SCORE_W + 1 > 4 ? SCORE_W + 1 : 4;
    localparam logic [AW-1:0] SMAX = AW'((1 << SCORE_W) - 1);
    localparam logic [2:0] NL = 3'(NUM_LEVELS);
    localparam logic [2:0] LV = 3'(LIVES);

    state_t             state_q, state_d;
    logic [2:0]         sync_q, sync_d, prev_q, prev_d, edge_q, edge_d;
    logic               line_s_q, line_s_d, line_q, line_d;
    logic [2:0]         level_q, level_d, mode_q, mode_d, lives_q, lives_d;
    logic [INV_W-1:0]   inv_q, inv_d;
    logic               run_q, run_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [KW-1:0]      kills_q, kills_d, target;
    logic [AW-1:0]      sum;
    logic               cont_e, kill_e, hit_e, done, last_kill;

    assign cont_e    = edge_q[2];
    assign kill_e    = edge_q[1];
    assign hit_e     = edge_q[0];
    assign target    = KW'(popcount(64'(INV_W'(lvl_mask(level_q)))));
    assign done      = kills_q == target;
    assign last_kill = kill_e && (kills_q + KW'(1) == target);
    assign sum       = AW'(score_q) + AW'(level_q);

    // line_crossed is delayed to line up with the edge detectors, so a kill and a line cross on one input cycle meet here.
    always_comb begin
        sync_d   = {cont_btn, ship_pixel & shot_pixel, player_hit};
        prev_d   = sync_q;
        edge_d   = sync_q & ~prev_q;
        line_s_d = line_crossed;
        line_d   = line_s_q;
        state_d  = state_q;
        level_d  = level_q;
        lives_d  = lives_q;
        score_d  = score_q;
        kills_d  = kills_q;
        case (state_q)
            S_IDLE: if (cont_e) begin
                score_d = '0;
                lives_d = LV;
                level_d = 3'd1;
                kills_d = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (kill_e) begin
                    score_d = sum > SMAX ? SMAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
                    kills_d = done ? kills_q : kills_q + KW'(1);
                end
                if (line_q) state_d = S_LOSE;
                else if (done) state_d = level_q < NL ? S_CLEAR : S_WIN;
                else if (hit_e && !last_kill) begin
                    lives_d = lives_q - 3'd1;
                    state_d = lives_q == 3'd1 ? S_LOSE : S_PAUSE;
                end
            end
            S_PAUSE: if (cont_e) state_d = S_PLAY;
            S_CLEAR: if (cont_e) begin
                level_d = level_q + 3'd1;
                kills_d = '0;
                state_d = S_PLAY;
            end
            default: ;
        endcase
        mode_d = mode_of(state_d);
        run_d  = state_d == S_PLAY;
        inv_d  = run_d ? INV_W'(lvl_mask(level_d)) : '0;
    end

    always_ff @(posedge s_clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            line_s_q <= 1'b0;
            line_q   <= 1'b0;
            level_q  <= '0;
            mode_q   <= M_IDLE;
            lives_q  <= LV;
            inv_q    <= '0;
            run_q    <= 1'b0;
            score_q  <= '0;
            kills_q  <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            edge_q   <= edge_d;
            line_s_q <= line_s_d;
            line_q   <= line_d;
            level_q  <= level_d;
            mode_q   <= mode_d;
            lives_q  <= lives_d;
            inv_q    <= inv_d;
            run_q    <= run_d;
            score_q  <= score_d;
            kills_q  <= kills_d;
        end
    end

    assign lvl_start  = run_q;
    assign player_en  = run_q;
    assign level      = level_q;
    assign mode       = mode_q;
    assign inv_en     = inv_q;
    assign lives_left = lives_q;
    assign score_bin  = score_q;

`ifdef GAME_SEQ_BCD_EN
    bin2bcd_seq #(.W(SCORE_W)) u_bcd (
        .s_clk (s_clk),
        .rst   (rst),
        .bin   (score_q),
        .bcd   (score_bcd)
    );
`endif

endmodule

// File: tb/tb_game_seq.sv
// tb_game_seq: scoreboard bench for game_seq with SCORE_W=4 so saturation is reachable in one game.
module tb_game_seq;
    logic        s_clk = 1'b0, rst = 1'b0;
    logic        cont_btn = 1'b0, ship_pixel = 1'b0, shot_pixel = 1'b0;
    logic        player_hit = 1'b0, line_crossed = 1'b0;
    logic        lvl_start, player_en;
    logic [2:0]  level, mode, lives_left;
    logic [23:0] inv_en;
    logic [3:0]  score_bin;
`ifdef GAME_SEQ_BCD_EN
    logic [11:0] score_bcd;
`endif

    game_seq #(.NUM_LEVELS(5), .INV_W(24), .SCORE_W(4), .LIVES(3)) dut (
        .s_clk        (s_clk),
        .rst          (rst),
        .cont_btn     (cont_btn),
        .ship_pixel   (ship_pixel),
        .shot_pixel   (shot_pixel),
        .player_hit   (player_hit),
        .line_crossed (line_crossed),
        .lvl_start    (lvl_start),
        .player_en    (player_en),
        .level        (level),
        .mode         (mode),
        .inv_en       (inv_en),
        .lives_left   (lives_left),
        .score_bin    (score_bin)
`ifdef GAME_SEQ_BCD_EN
        ,
        .score_bcd    (score_bcd)
`endif
    );

    always #5 s_clk = ~s_clk;

    typedef struct {
        string       tag;
        logic [2:0]  level, mode, lives;
        logic [23:0] inv;
        logic [3:0]  score;
        logic        run;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0, n_fail = 0;
    int          sc = 0, lvl = 0;
    int          tgt[5] = '{8, 12, 16, 20, 24};
    logic [23:0] msk[5] = '{24'h00aa55, 24'h005aff, 24'haa55ff, 24'h3cffff, 24'hffffff};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge s_clk);
    endtask

    task automatic push(input string tag, input int l, input int md, input int lv, input logic [23:0] inv);
        exp_t e;
        e.tag   = tag;
        e.level = 3'(l);
        e.mode  = 3'(md);
        e.lives = 3'(lv);
        e.inv   = inv;
        e.score = 4'(sc);
        e.run   = md == 1;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".level"}, 32'(level), 32'(e.level));
        check({e.tag, ".mode"}, 32'(mode), 32'(e.mode));
        check({e.tag, ".lives"}, 32'(lives_left), 32'(e.lives));
        check({e.tag, ".inv_en"}, 32'(inv_en), 32'(e.inv));
        check({e.tag, ".score"}, 32'(score_bin), 32'(e.score));
        check({e.tag, ".lvl_start"}, 32'(lvl_start), 32'(e.run));
        check({e.tag, ".player_en"}, 32'(player_en), 32'(e.run));
    endtask

    task automatic cont();
        cont_btn = 1'b1;
        tick(1);
        cont_btn = 1'b0;
        tick(4);
    endtask

    task automatic kill(input int n, input bit scored);
        for (int i = 0; i < n; i++) begin
            ship_pixel = 1'b1;
            shot_pixel = 1'b1;
            tick(1);
            ship_pixel = 1'b0;
            shot_pixel = 1'b0;
            tick(1);
            if (scored) sc = sc + lvl > 15 ? 15 : sc + lvl;
        end
        tick(4);
    endtask

    task automatic hit();
        player_hit = 1'b1;
        tick(1);
        player_hit = 1'b0;
        tick(4);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        sc  = 0;
        lvl = 0;
    endtask

    initial begin
        tick(3);
        push("reset", 0, 0, 3, 24'h0); pop_cmp();
        rst = 1'b1;
        tick(1);
        cont(); lvl = 1;
        push("start", 1, 1, 3, 24'h00aa55); pop_cmp();
        kill(7, 1);
        push("l1_seven", 1, 1, 3, 24'h00aa55); pop_cmp();
        kill(1, 1);
        push("l1_clear", 1, 2, 3, 24'h0); pop_cmp();
        kill(1, 0);
        push("clear_ignore", 1, 2, 3, 24'h0); pop_cmp();
        cont(); lvl = 2;
        push("l2_start", 2, 1, 3, 24'h005aff); pop_cmp();
        ship_pixel = 1'b1;
        shot_pixel = 1'b1;
        tick(10);
        ship_pixel = 1'b0;
        shot_pixel = 1'b0;
        tick(4);
        sc = sc + lvl;
        push("held_pixels", 2, 1, 3, 24'h005aff); pop_cmp();
        hit();
        push("hit1", 2, 2, 2, 24'h0); pop_cmp();
        kill(1, 0);
        push("pause_ignore", 2, 2, 2, 24'h0); pop_cmp();
        cont();
        push("resume1", 2, 1, 2, 24'h005aff); pop_cmp();
        kill(3, 1);
        push("saturate", 2, 1, 2, 24'h005aff); pop_cmp();
        hit();
        push("hit2", 2, 2, 1, 24'h0); pop_cmp();
        cont();
        push("resume2", 2, 1, 1, 24'h005aff); pop_cmp();
        kill(7, 1);
        push("l2_eleven", 2, 1, 1, 24'h005aff); pop_cmp();
        ship_pixel = 1'b1;
        shot_pixel = 1'b1;
        player_hit = 1'b1;
        tick(1);
        ship_pixel = 1'b0;
        shot_pixel = 1'b0;
        player_hit = 1'b0;
        tick(4);
        sc = sc + lvl > 15 ? 15 : sc + lvl;
        push("kill_and_hit", 2, 2, 1, 24'h0); pop_cmp();
        cont(); lvl = 3;
        push("l3_start", 3, 1, 1, 24'haa55ff); pop_cmp();
        hit();
        push("hit3_lose", 3, 4, 0, 24'h0); pop_cmp();
        cont();
        push("lose_hold", 3, 4, 0, 24'h0); pop_cmp();

        do_reset();
        push("reset_b", 0, 0, 3, 24'h0); pop_cmp();
        cont(); lvl = 1;
        kill(7, 1);
        push("b_seven", 1, 1, 3, 24'h00aa55); pop_cmp();
        ship_pixel   = 1'b1;
        shot_pixel   = 1'b1;
        line_crossed = 1'b1;
        tick(1);
        ship_pixel   = 1'b0;
        shot_pixel   = 1'b0;
        line_crossed = 1'b0;
        tick(4);
        sc = sc + lvl;
        push("kill_and_line", 1, 4, 3, 24'h0); pop_cmp();

        do_reset();
        cont();
        push("c_start", 1, 1, 3, msk[0]); pop_cmp();
        for (int l = 1; l <= 5; l++) begin
            lvl = l;
            kill(tgt[l-1], 1);
            push($sformatf("c_end_l%0d", l), l, l < 5 ? 2 : 3, 3, 24'h0); pop_cmp();
            if (l < 5) begin
                cont();
                push($sformatf("c_start_l%0d", l + 1), l + 1, 1, 3, msk[l]); pop_cmp();
            end
        end
        cont();
        push("win_hold", 5, 3, 3, 24'h0); pop_cmp();
`ifdef GAME_SEQ_BCD_EN
        check("score_bcd", 32'(score_bcd), 32'h015);
`endif

        do_reset();
        cont(); lvl = 1;
        kill(3, 1);
        push("d_mid", 1, 1, 3, 24'h00aa55); pop_cmp();
        rst = 1'b0;
        tick(1);
        sc = 0;
        push("mid_reset", 0, 0, 3, 24'h0); pop_cmp();
        rst = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
